stoplight_timer: RTL
====================

Name: stoplight_timer

Overview:
Phase-duration timer that sits directly downstream of the stoplight FSM and closes its control loop.
- Consumes the FSM's count_en, count_clr and one-hot red/yellow/green outputs.
- Produces count_max, which the FSM uses to advance phases.
- Each light phase has its own duration in prescaled ticks, so the FSM needs no knowledge of timing.

Parameters:
- CNT_W, 8: width of the tick counter.
- PRESCALE, 10: clk cycles per tick. Legal range 1..65535.
- RED_TICKS, 30: red phase length in ticks. Legal range 1..2^CNT_W.
- GREEN_TICKS, 25: green phase length in ticks. Same range.
- YELLOW_TICKS, 5: yellow phase length in ticks. Same range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- count_en  in  1  advance the timer while high.
- count_clr  in  1  restart the current phase timing.
- red  in  1  FSM red output; selects the terminal count.
- yellow  in  1  FSM yellow output; selects the terminal count.
- green  in  1  FSM green output; selects the terminal count.
- count_max  out  1  one-cycle pulse at phase expiry; registered.
- count  out  CNT_W  current tick count within the phase.
- tick  out  1  prescaler strobe; registered.

Behaviour:
- Reset: rst high at a clk edge clears prescaler, count, tick and count_max to 0. Reset wins over all inputs.
- Terminal select (combinational), priority red > yellow > green:
  - term = RED_TICKS, YELLOW_TICKS or GREEN_TICKS.
  - No light high: no terminal; count holds and count_max stays 0.
- Priority per cycle: rst > count_clr > count_en > hold.
- count_clr: next edge sets prescaler=0, count=0, tick=0, count_max=0, regardless of count_en.
- Prescaler: when count_en=1, increments 0..PRESCALE-1 and wraps. In the wrap cycle, tick=1 for the next cycle. When count_en=0, prescaler, count and tick hold/clear as follows: prescaler holds, tick=0.
- Counter: advances on an enabled wrap cycle.
  - If count == term-1: count <= 0 and count_max <= 1 for exactly one cycle.
  - Otherwise count <= count+1.
- count_max drops after one cycle, even if count_en stays high.
- Latency: from count_clr released with count_en held high, count_max is high in cycle PRESCALE*term, counting the first enabled cycle as cycle 0.
- Continuous run without clr: count_max repeats every PRESCALE*term cycles.
- Light change mid-phase: the new term applies immediately. If count >= new term-1, the next wrap fires count_max and sets count to 0. Count never exceeds term-1 after that wrap.
- count_clr and count_max in the same cycle: count_max still reads 1 this cycle; clr clears it next edge.
- Reset mid-phase: all state returns to 0 next edge. No pending count_max survives.

Optional Feature:
- Macro: STOPLIGHT_TIMER_FAST_SIM_EN.
- Defined: effective prescale is 1, so tick is high every enabled cycle and phases last term cycles. Intended for quick simulation and bring-up.
- Undefined: PRESCALE is used as given.

Decomposition:
- Package stoplight_pkg holds:
  - light_t enum {LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN, LIGHT_NONE}.
  - Default duration constants DEF_RED_TICKS=30, DEF_GREEN_TICKS=25, DEF_YELLOW_TICKS=5.
  - Function to encode the one-hot lights into light_t.
- Sub-module tick_gen: the prescaler.
  - Parameter PRESCALE.
  - Inputs clk, rst, en, clr; output tick.
  - The timer instantiates one copy.

Test Plan:
- Reset: rst=1 for 2 cycles with count_en=1 and red=1 -> count=0, tick=0, count_max=0 throughout; cycle after release, count still 0.
- Yellow phase: PRESCALE=2, YELLOW_TICKS=5, pulse clr, then count_en=1 and yellow=1 -> count_max high only in cycle 10; count sequence 0,1,2,3,4,0.
- Free run: red=1, defaults, en held high -> count_max pulses at cycles 300, 600, 900, each exactly 1 cycle wide.
- Enable gap: green=1, PRESCALE=2, GREEN_TICKS=3, en low for 4 cycles mid-phase -> count and prescaler frozen; count_max delayed by exactly 4 cycles, to cycle 10.
- Light change: red active with count=20, switch to yellow (term 5) -> next tick gives count_max=1 and count=0.
- Clr priority and no-light: count_clr=1 and count_en=1 together -> count=0 next cycle. All lights 0 for 100 enabled cycles -> count_max never asserted.

Source files
------------

// File: rtl/stoplight_timer_pkg.sv
// Shared types and defaults for the stoplight phase timer.
// Optional build macro STOPLIGHT_TIMER_FAST_SIM_EN is consumed by stoplight_timer.
package stoplight_pkg;

   typedef enum logic [1:0] {
      LIGHT_RED,
      LIGHT_YELLOW,
      LIGHT_GREEN,
      LIGHT_NONE
   } light_t;

   localparam int DEF_RED_TICKS    = 30;
   localparam int DEF_GREEN_TICKS  = 25;
   localparam int DEF_YELLOW_TICKS = 5;

   // Red dominates, then yellow, then green, so a glitchy FSM never selects two terms.
   function automatic light_t encode_lights(input logic red, input logic yellow,
                                            input logic green);
      if (red)         return LIGHT_RED;
      else if (yellow) return LIGHT_YELLOW;
      else if (green)  return LIGHT_GREEN;
      else             return LIGHT_NONE;
   endfunction

endpackage

// File: rtl/stoplight_timer_tick_gen.sv
// Prescaler for the stoplight timer: wraps every PRESCALE enabled cycles.
// Provides the combinational wrap strobe and the registered tick that follows it.
module tick_gen #(
   parameter int PRESCALE = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick,
   output logic wrap
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] prescaler;

   // The counter above needs the wrap in the same cycle, one cycle ahead of tick.
   assign wrap = en && (prescaler == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         prescaler <= '0;
         tick      <= 1'b0;
      end else if (en) begin
         prescaler <= wrap ? '0 : prescaler + 1'b1;
         tick      <= wrap;
      end else begin
         tick      <= 1'b0;
      end
   end

endmodule

// File: rtl/stoplight_timer.sv
// Phase-duration timer for the stoplight FSM: pulses count_max when the active light's term expires.
// Define STOPLIGHT_TIMER_FAST_SIM_EN to force a prescale of 1 for quick bring-up simulation.
module stoplight_timer
   import stoplight_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int PRESCALE     = 10,
   parameter int RED_TICKS    = DEF_RED_TICKS,
   parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
   parameter int YELLOW_TICKS = DEF_YELLOW_TICKS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             count_en,
   input  logic             count_clr,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   output logic             count_max,
   output logic [CNT_W-1:0] count,
   output logic             tick
);

`ifdef STOPLIGHT_TIMER_FAST_SIM_EN
   localparam int EFF_PRESCALE = 1;
`else
   localparam int EFF_PRESCALE = PRESCALE;
`endif

   light_t           light;
   logic [CNT_W-1:0] term_m1;
   logic             has_term;
   logic             wrap;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      light    = encode_lights(red, yellow, green);
      has_term = 1'b1;
      term_m1  = '0;
      case (light)
         LIGHT_RED:    term_m1 = CNT_W'(RED_TICKS - 1);
         LIGHT_YELLOW: term_m1 = CNT_W'(YELLOW_TICKS - 1);
         LIGHT_GREEN:  term_m1 = CNT_W'(GREEN_TICKS - 1);
         default:      has_term = 1'b0;
      endcase
   end

   tick_gen #(
      .PRESCALE(EFF_PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (count_en),
      .clr  (count_clr),
      .tick (tick),
      .wrap (wrap)
   );

   // ">=" rather than "==" so a shorter term chosen mid-phase still expires on the next wrap.
   always_ff @(posedge clk) begin
      if (rst || count_clr) begin
         count     <= '0;
         count_max <= 1'b0;
      end else begin
         count_max <= 1'b0;
         if (wrap && has_term) begin
            if (count >= term_m1) begin
               count     <= '0;
               count_max <= 1'b1;
            end else begin
               count     <= count + 1'b1;
            end
         end
      end
   end

endmodule
